// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequential radix-2 Booth multiplier controller that
// time-shares one external WIDTH-bit adder to form a signed 2*WIDTH product.
// Optional build macro: BOOTH_EARLY_TERM_EN (finishes early once the
// remaining multiplier bits and q_m1 are all equal).
module booth_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned    KW     = $clog2(WIDTH + 1);
  localparam logic [KW-1:0]  K_LAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_m1;
  logic [KW-1:0]    k;
  logic             early_hit;
  logic             sign_bit;

  // True sign of the (WIDTH+1)-bit sum, so M = -2^(WIDTH-1) still works.
  assign sign_bit = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;

  assign busy = (state == CALC);
  assign done = (state == DONE);

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH:0]   et_bits;
  logic [WIDTH:0]   et_mask;
  logic [KW-1:0]    et_shift;
  logic [2*WIDTH-1:0] shifted;

  // Detect that the remaining Booth pairs would all be add-0, and precompute
  // the equivalent arithmetic shift of {A,Q} by the remaining iteration count.
  always_comb begin
    et_bits = {q, q_m1};
    et_mask = '0;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      et_mask[i] = ((i + 32'(k)) <= WIDTH);
    end
    early_hit = (state == CALC) &&
                (((et_bits & et_mask) == '0) || ((et_bits & et_mask) == et_mask));
    et_shift  = KW'(WIDTH) - k;
    shifted   = $signed({acc, q}) >>> et_shift;
  end
`else
  assign early_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and adder operand selection from the current Booth pair.
  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        if (early_hit) begin
          state_nxt = DONE;
        end else begin
          add_a = acc;
          case ({q[0], q_m1})
            2'b01:   add_b = m;
            2'b10: begin
              add_b   = ~m;
              add_cin = 1'b1;
            end
            default: add_b = '0;
          endcase
          if (k == K_LAST) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration shift/accumulate, and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      q_m1    <= 1'b0;
      k       <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m    <= multiplicand;
            q    <= multiplier;
            acc  <= '0;
            q_m1 <= 1'b0;
            k    <= '0;
          end
        end
        CALC: begin
`ifdef BOOTH_EARLY_TERM_EN
          if (early_hit) begin
            {acc, q} <= shifted;
            product  <= shifted;
          end else
`endif
          begin
            acc  <= {sign_bit, add_sum[WIDTH-1:1]};
            q    <= {add_sum[0], q[WIDTH-1:1]};
            q_m1 <= q[0];
            k    <= k + 1'b1;
            if (k == K_LAST) begin
              product <= {sign_bit, add_sum, q[WIDTH-1:1]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl with an ideal external adder.
module tb_booth_seq_ctrl;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic            add_cin;
  logic [W-1:0]    add_sum;
  logic            add_cout;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got product %0h with no request outstanding", product);
      end else begin
        check("product", product, exp_q.pop_front());
      end
    end
  end

  // Called #1 after the edge that accepted start; returns at #1 after the
  // edge that raised done (or after a bounded timeout).
  task automatic wait_done(output int lat, output int bc);
    bit seen;
    lat  = 0;
    bc   = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      lat++;
      if (busy) bc++;
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within 100 cycles, required done");
    end
  endtask

  task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] qv,
                         input logic [2*W-1:0] expv, output int lat, output int bc);
    @(negedge clk);
    mcand  = m;
    mplier = qv;
    start  = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    @(posedge clk);
    #1;
    check("done_pulse_width", done, 1'b0);
  endtask

  initial begin
    int lat;
    int bc;
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_product", product, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    run_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, lat, bc);
`ifndef BOOTH_EARLY_TERM_EN
    check("latency_3x5", lat, 33);
    check("busy_cycles_3x5", bc, 32);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("product_held_idle", product, 64'h0000_0000_0000_000F);

    run_mul(-32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, lat, bc);
`ifndef BOOTH_EARLY_TERM_EN
    check("busy_cycles_m7x6", bc, 32);
`endif
    run_mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, lat, bc);
    run_mul(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, lat, bc);

    // Start re-pulsed in CALC and in DONE must be ignored.
    @(negedge clk);
    mcand  = 32'd3;
    mplier = 32'h5555_5555;
    start  = 1'b1;
    exp_q.push_back(64'h0000_0000_FFFF_FFFF);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    mcand  = 32'd99;
    mplier = 32'd99;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("repulse_calc_busy", busy, 1'b1);
    wait_done(lat, bc);
    mcand  = 32'd50;
    mplier = 32'd2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("repulse_done_ignored", busy, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("repulse_queue_empty", exp_q.size(), 0);
    check("repulse_product", product, 64'h0000_0000_FFFF_FFFF);

    // Reset after 10 iterations aborts with no done pulse.
    @(negedge clk);
    mcand  = 32'd12345;
    mplier = 32'h5555_5555;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_product", product, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", done, 1'b0);

    run_mul(32'd4, 32'd4, 64'h0000_0000_0000_0010, lat, bc);
`ifndef BOOTH_EARLY_TERM_EN
    check("latency_4x4", lat, 33);
`endif

`ifdef BOOTH_EARLY_TERM_EN
    run_mul(32'h1234, 32'd0, 64'h0, lat, bc);
    check("early_calc_cycles_q0", bc, 1);
    check("early_latency_q0", lat, 2);
    run_mul(32'h1234, 32'd1, 64'h0000_0000_0000_1234, lat, bc);
    check("early_calc_cycles_q1", bc, 3);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
